obi_dma_copy: RTL and testbench

//   OBI initiator that copies LEN 32-bit words from a source address range to a

---
 rtl/obi_dma_copy_if.sv | 23 ++
 rtl/obi_dma_copy.sv | 154 +++++++++++++++
 tb/tb_obi_dma_copy.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_dma_copy_if.sv
// OBI data-port bundle between the copy engine (master) and a memory responder (slave).
// illegal is the responder's bad-access flag, meaningful only in a req && gnt cycle.
interface obi_dma_copy_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        illegal;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, illegal
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, illegal
    );
endinterface

// File: rtl/obi_dma_copy.sv
// OBI bulk-copy engine: reads one word from src, writes it to dst, repeats len times.
// One transaction outstanding at a time; an illegal access ends the copy with err_o set.
module obi_dma_copy #(
    parameter int unsigned LEN_W   = 16,
    parameter logic [3:0]  BE_FULL = 4'hF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    obi_dma_copy_if.master   obi
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [31:0]      r_rd_addr;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_buf;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_words;
    logic [LEN_W-1:0] w_words_inc;
    logic             r_err;
    logic             w_start;
    logic             w_grant;

    assign w_start     = (r_state == StIdle) && start_i;
    assign w_grant     = obi.req && obi.gnt;
    assign w_words_inc = r_words + LEN_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_err doubles as the abort flag: once set, the pending response ends the copy.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_next = (len_i == '0) ? StDone : StRdReq;
                end
            end
            StRdReq: begin
                if (obi.gnt) w_state_next = StRdWait;
            end
            StRdWait: begin
                if (obi.rvalid) w_state_next = r_err ? StDone : StWrReq;
            end
            StWrReq: begin
                if (obi.gnt) w_state_next = StWrWait;
            end
            StWrWait: begin
                if (obi.rvalid) begin
                    w_state_next = (r_err || (w_words_inc == r_len)) ? StDone : StRdReq;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_buf     <= '0;
            r_len     <= '0;
            r_words   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_start) begin
                r_rd_addr <= src_addr_i & ~32'h3;
                r_wr_addr <= dst_addr_i & ~32'h3;
                r_len     <= len_i;
                r_words   <= '0;
                r_err     <= 1'b0;
            end
            if (w_grant && obi.illegal) begin
                r_err <= 1'b1;
            end
            if ((r_state == StRdWait) && obi.rvalid) begin
                r_buf <= obi.rdata;
            end
            // Addresses advance by a word and wrap modulo 2^32 naturally.
            if ((r_state == StWrWait) && obi.rvalid && !r_err) begin
                r_words   <= w_words_inc;
                r_rd_addr <= r_rd_addr + 32'd4;
                r_wr_addr <= r_wr_addr + 32'd4;
            end
        end
    end

    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        obi.req   = 1'b0;
        obi.we    = 1'b0;
        obi.be    = 4'h0;
        obi.addr  = 32'h0;
        obi.wdata = 32'h0;
        unique case (r_state)
            StRdReq: begin
                busy_o   = 1'b1;
                obi.req  = 1'b1;
                obi.be   = BE_FULL;
                obi.addr = r_rd_addr;
            end
            StWrReq: begin
                busy_o    = 1'b1;
                obi.req   = 1'b1;
                obi.we    = 1'b1;
                obi.be    = BE_FULL;
                obi.addr  = r_wr_addr;
                obi.wdata = r_buf;
            end
            StRdWait, StWrWait: begin
                busy_o = 1'b1;
            end
            StDone: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign err_o        = r_err;
    assign words_done_o = r_words;

endmodule

// File: tb/tb_obi_dma_copy.sv
// Bench for obi_dma_copy: SRAM-like responder, directed scenarios plus randomized copies
// checked against a word-level copy model and the expected request sequence.
module tb_obi_dma_copy;
    localparam int unsigned LEN_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic [31:0]      src_addr_i = '0;
    logic [31:0]      dst_addr_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [LEN_W-1:0] words_done_o;

    int checks = 0;
    int errors = 0;

    obi_dma_copy_if obi ();

    obi_dma_copy #(
        .LEN_W   (LEN_W),
        .BE_FULL (4'hF)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_done_o (words_done_o),
        .obi          (obi)
    );

    always #5 clk_i = ~clk_i;

    // Responder: grant follows req unless stalled, response one cycle after the grant.
    logic hold_gnt = 1'b0;
    logic gnt_ok = 1'b1;
    logic illegal_en = 1'b0;
    logic [31:0] init_mem [0:8191];
    logic [31:0] mem_w [0:8191];
    bit          written [0:8191];
    logic [31:0] log_addr [$];
    bit          log_we [$];

    assign obi.gnt     = obi.req && !hold_gnt && gnt_ok;
    assign obi.illegal = illegal_en && obi.req && obi.we && (obi.addr < 32'h8000_0000);

    function automatic int widx(input logic [31:0] a);
        return int'(a[14:2]);
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int k = widx(a);
        return written[k] ? mem_w[k] : init_mem[k];
    endfunction

    always @(posedge clk_i) begin
        obi.rvalid <= 1'b0;
        obi.rdata  <= 32'h0;
        if (obi.req && obi.gnt) begin
            log_addr.push_back(obi.addr);
            log_we.push_back(obi.we);
            obi.rvalid <= 1'b1;
            if (obi.we) begin
                if (!obi.illegal) begin
                    mem_w[widx(obi.addr)]   <= obi.wdata;
                    written[widx(obi.addr)] <= 1'b1;
                end
            end else begin
                obi.rdata <= rd_word(obi.addr);
            end
        end
    end

    // Cycle k=1 is the cycle right after the edge that samples start_i.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input logic [31:0] stall_addr, input int stall_n,
                            input bit rand_gnt, input bit poke, input int max_cyc,
                            output int done_cyc, output int done_cnt, output bit busy_seen,
                            output bit req_seen, output bit stable_ok);
        int  left = 0;
        bit  stalled = 1'b0;
        @(negedge clk_i);
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = LEN_W'(len);
        start_i    = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        done_cyc  = -1;
        done_cnt  = 0;
        busy_seen = 1'b0;
        req_seen  = 1'b0;
        stable_ok = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk_i);
            gnt_ok = rand_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (busy_o) busy_seen = 1'b1;
            if (obi.req) req_seen = 1'b1;
            if (hold_gnt) begin
                if (!(obi.req === 1'b1 && obi.we === 1'b0 && obi.addr === stall_addr &&
                      obi.be === 4'hF)) stable_ok = 1'b0;
                left--;
                if (left == 0) hold_gnt = 1'b0;
            end else if (!stalled && stall_n > 0 && obi.req && !obi.we &&
                         obi.addr == stall_addr) begin
                hold_gnt = 1'b1;
                left     = stall_n;
                stalled  = 1'b1;
            end
            if (poke && k == 3) begin
                start_i    = 1'b1;
                src_addr_i = 32'h1234_5670;
                dst_addr_i = 32'h8000_0F00;
                len_i      = LEN_W'(7);
            end else if (poke && k == 4) begin
                start_i = 1'b0;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        gnt_ok   = 1'b1;
        hold_gnt = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, err_o, obi.req, obi.we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {busy_o, done_o, err_o, obi.req, obi.we});
        end
        checks++;
        if (words_done_o !== '0 || obi.addr !== 32'h0 || obi.be !== 4'h0) begin
            errors++;
            $display("FAIL reset_vals words=%0d addr=%h be=%h want 0", words_done_o, obi.addr, obi.be);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        int dc, dn, base;
        bit bs, rs, st;
        init_mem[0] = 32'h11;
        init_mem[1] = 32'h22;
        init_mem[2] = 32'h33;
        base = log_addr.size();
        run_copy(32'h8000_0000, 32'h8000_0800, 3, 32'h0, 0, 1'b0, 1'b0, 100, dc, dn, bs, rs, st);
        checks++;
        if (dc !== 13 || dn !== 1) begin
            errors++;
            $display("FAIL basic_done cycle=%0d count=%0d want 13/1", dc, dn);
        end
        checks++;
        if (words_done_o !== 16'd3 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_status words=%0d err=%b want 3/0", words_done_o, err_o);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_word(32'h8000_0800 + 32'(4 * i)) !== 32'(8'h11 * (i + 1))) begin
                errors++;
                $display("FAIL basic_data[%0d] got %h want %h", i,
                         rd_word(32'h8000_0800 + 32'(4 * i)), 32'(8'h11 * (i + 1)));
            end
        end
        checks++;
        if (log_addr.size() - base !== 6) begin
            errors++;
            $display("FAIL basic_txns got %0d want 6", log_addr.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_addr[base + 2 * i] !== 32'h8000_0000 + 32'(4 * i) ||
                    log_addr[base + 2 * i + 1] !== 32'h8000_0800 + 32'(4 * i) ||
                    log_we[base + 2 * i] !== 1'b0 || log_we[base + 2 * i + 1] !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_seq[%0d] got %h/%h want %h/%h", i, log_addr[base + 2 * i],
                             log_addr[base + 2 * i + 1], 32'h8000_0000 + 32'(4 * i),
                             32'h8000_0800 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_len_zero();
        int dc, dn, base;
        bit bs, rs, st;
        base = log_addr.size();
        run_copy(32'h8000_0000, 32'h8000_0800, 0, 32'h0, 0, 1'b0, 1'b0, 20, dc, dn, bs, rs, st);
        checks++;
        if (dc !== 1 || dn !== 1) begin
            errors++;
            $display("FAIL len0_done cycle=%0d count=%0d want 1/1", dc, dn);
        end
        checks++;
        if (rs !== 1'b0 || bs !== 1'b0 || log_addr.size() !== base) begin
            errors++;
            $display("FAIL len0_quiet req=%b busy=%b txns=%0d want 0/0/0", rs, bs,
                     log_addr.size() - base);
        end
    endtask

    task automatic test_gnt_stall();
        int dc, dn;
        bit bs, rs, st;
        run_copy(32'h8000_0000, 32'h8000_0900, 3, 32'h8000_0004, 5, 1'b0, 1'b0, 100,
                 dc, dn, bs, rs, st);
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL stall_stable got %b want 1", st);
        end
        checks++;
        if (dc !== 18 || dn !== 1) begin
            errors++;
            $display("FAIL stall_done cycle=%0d count=%0d want 18/1", dc, dn);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_word(32'h8000_0900 + 32'(4 * i)) !== init_mem[i]) begin
                errors++;
                $display("FAIL stall_data[%0d] got %h want %h", i,
                         rd_word(32'h8000_0900 + 32'(4 * i)), init_mem[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int dc, dn, base, after;
        bit bs, rs, st, req_late;
        illegal_en = 1'b1;
        base = log_addr.size();
        run_copy(32'h8000_0000, 32'h7FFF_FFF8, 4, 32'h0, 0, 1'b0, 1'b0, 100, dc, dn, bs, rs, st);
        checks++;
        if (err_o !== 1'b1 || words_done_o !== '0) begin
            errors++;
            $display("FAIL illegal_status err=%b words=%0d want 1/0", err_o, words_done_o);
        end
        checks++;
        if (dc !== 5 || dn !== 1) begin
            errors++;
            $display("FAIL illegal_done cycle=%0d count=%0d want 5/1", dc, dn);
        end
        after = log_addr.size();
        req_late = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (obi.req) req_late = 1'b1;
        end
        checks++;
        if (after - base !== 2 || log_addr.size() !== after || req_late !== 1'b0) begin
            errors++;
            $display("FAIL illegal_noreq txns=%0d late=%0d req=%b want 2/0/0", after - base,
                     log_addr.size() - after, req_late);
        end
        run_copy(32'h8000_0000, 32'h8000_0C00, 1, 32'h0, 0, 1'b0, 1'b0, 100, dc, dn, bs, rs, st);
        checks++;
        if (err_o !== 1'b0 || words_done_o !== 16'd1 || rd_word(32'h8000_0C00) !== init_mem[0]) begin
            errors++;
            $display("FAIL illegal_recover err=%b words=%0d data=%h want 0/1/%h", err_o,
                     words_done_o, rd_word(32'h8000_0C00), init_mem[0]);
        end
        illegal_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dc, dn;
        bit bs, rs, st, found, quiet;
        @(negedge clk_i);
        src_addr_i = 32'h8000_0000;
        dst_addr_i = 32'h8000_0A00;
        len_i      = LEN_W'(3);
        start_i    = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk_i);
            if (obi.req && obi.we && obi.addr == 32'h8000_0A04) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_reach got no write of word 2 want one within 40 cycles");
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (obi.req !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop req=%b busy=%b want 0/0", obi.req, busy_o);
        end
        rst_ni = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            if (obi.req || busy_o || done_o || words_done_o != '0 || err_o) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_late_rvalid got activity want idle");
        end
        for (int i = 0; i < 3; i++) init_mem[16 + i] = $urandom;
        run_copy(32'h8000_0040, 32'h8000_0A00, 3, 32'h0, 0, 1'b0, 1'b0, 100, dc, dn, bs, rs, st);
        checks++;
        if (dc !== 13 || words_done_o !== 16'd3) begin
            errors++;
            $display("FAIL rstmid_rerun cycle=%0d words=%0d want 13/3", dc, words_done_o);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_word(32'h8000_0A00 + 32'(4 * i)) !== init_mem[16 + i]) begin
                errors++;
                $display("FAIL rstmid_data[%0d] got %h want %h", i,
                         rd_word(32'h8000_0A00 + 32'(4 * i)), init_mem[16 + i]);
            end
        end
    endtask

    task automatic test_wrap();
        int dc, dn, base;
        bit bs, rs, st;
        logic [31:0] want_a [4];
        want_a = '{32'hFFFF_FFFC, 32'h8000_0B00, 32'h0000_0000, 32'h8000_0B04};
        init_mem[8191] = $urandom;
        base = log_addr.size();
        run_copy(32'hFFFF_FFFC, 32'h8000_0B00, 2, 32'h0, 0, 1'b0, 1'b1, 100, dc, dn, bs, rs, st);
        checks++;
        if (log_addr.size() - base !== 4 || dc !== 9 || dn !== 1) begin
            errors++;
            $display("FAIL wrap_txns txns=%0d cycle=%0d count=%0d want 4/9/1",
                     log_addr.size() - base, dc, dn);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_addr[base + i] !== want_a[i]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d] got %h want %h", i, log_addr[base + i], want_a[i]);
                end
            end
        end
        checks++;
        if (rd_word(32'h8000_0B00) !== init_mem[8191] || rd_word(32'h8000_0B04) !== init_mem[0]) begin
            errors++;
            $display("FAIL wrap_data got %h/%h want %h/%h", rd_word(32'h8000_0B00),
                     rd_word(32'h8000_0B04), init_mem[8191], init_mem[0]);
        end
    endtask

    task automatic test_random();
        int dc, dn, base, len;
        bit bs, rs, st, rg;
        logic [31:0] src, dst, s_al, d_al;
        for (int it = 0; it < 20; it++) begin
            len  = $urandom_range(1, 12);
            rg   = (it % 2) == 1;
            src  = 32'h8000_1000 + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3));
            dst  = 32'h8000_4000 + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(0, 3));
            s_al = src & ~32'h3;
            d_al = dst & ~32'h3;
            for (int i = 0; i < len; i++) init_mem[widx(s_al + 32'(4 * i))] = $urandom;
            base = log_addr.size();
            run_copy(src, dst, len, 32'h0, 0, rg, 1'b0, 400, dc, dn, bs, rs, st);
            checks++;
            if (dn !== 1 || err_o !== 1'b0 || words_done_o !== LEN_W'(len) ||
                (!rg && dc !== 4 * len + 1)) begin
                errors++;
                $display("FAIL rand%0d_status done=%0d/%0d err=%b words=%0d want %0d/1/0/%0d",
                         it, dc, dn, err_o, words_done_o, 4 * len + 1, len);
            end
            for (int i = 0; i < len; i++) begin
                checks++;
                if (rd_word(d_al + 32'(4 * i)) !== init_mem[widx(s_al + 32'(4 * i))] ||
                    log_addr[base + 2 * i] !== s_al + 32'(4 * i) ||
                    log_addr[base + 2 * i + 1] !== d_al + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d data=%h want %h raddr=%h waddr=%h", it, i,
                             rd_word(d_al + 32'(4 * i)), init_mem[widx(s_al + 32'(4 * i))],
                             log_addr[base + 2 * i], log_addr[base + 2 * i + 1]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) init_mem[i] = $urandom;
        test_reset();
        test_basic();
        test_len_zero();
        test_gnt_stall();
        test_illegal();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
